// File: rtl/ecap5_dproc_pkg.sv
// ============================================================================
//  Module   : ecap5_dproc_pkg
//  Brief    : Shared arbiter types and constants for the processor-side bus.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package ecap5_dproc_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    localparam int ARB_MAX_PORTS = 8;

    // Index width for an n-entry port vector (at least one bit).
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_priority_picker.sv
// ============================================================================
//  Module   : rr_priority_picker
//  Brief    : Combinational round-robin picker: first request at or after prio_i.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module rr_priority_picker
    import ecap5_dproc_pkg::*;
#(
    parameter int NPORTS = 3
)(
    input  logic [NPORTS-1:0]              req_i,
    input  logic [idx_width(NPORTS)-1:0]   prio_i,
    output logic [idx_width(NPORTS)-1:0]   grant_o,
    output logic                           valid_o
);

    localparam int IDX_W = idx_width(NPORTS);

    logic [IDX_W-1:0] w_idx;

    // Walk from the farthest offset back to prio_i so the nearest request wins.
    always_comb begin
        grant_o = '0;
        valid_o = 1'b0;
        w_idx   = '0;
        for (int i = NPORTS - 1; i >= 0; i--) begin
            w_idx = IDX_W'((int'(prio_i) + i) % NPORTS);
            if (req_i[w_idx]) begin
                grant_o = w_idx;
                valid_o = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/wb_rr_arbiter.sv
// ============================================================================
//  Module   : wb_rr_arbiter
//  Brief    : N-port Wishbone B4 pipelined round-robin arbiter with bounded
//             outstanding tracking. ECAP5_DPROC_ARB_BURST_LIMIT_EN adds a
//             per-grant strobe limit of MAX_BURST.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module wb_rr_arbiter
    import ecap5_dproc_pkg::*;
#(
    parameter int NPORTS          = 3,
    parameter int MAX_OUTSTANDING = 4,
    parameter int MAX_BURST       = 8
)(
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NPORTS*32-1:0] s_wb_adr_i,
    input  logic [NPORTS*32-1:0] s_wb_dat_i,
    output logic [NPORTS*32-1:0] s_wb_dat_o,
    input  logic [NPORTS-1:0]    s_wb_we_i,
    input  logic [NPORTS*4-1:0]  s_wb_sel_i,
    input  logic [NPORTS-1:0]    s_wb_stb_i,
    input  logic [NPORTS-1:0]    s_wb_cyc_i,
    output logic [NPORTS-1:0]    s_wb_ack_o,
    output logic [NPORTS-1:0]    s_wb_stall_o,
    output logic [31:0]          m_wb_adr_o,
    output logic [31:0]          m_wb_dat_o,
    output logic                 m_wb_we_o,
    output logic [3:0]           m_wb_sel_o,
    output logic                 m_wb_stb_o,
    output logic                 m_wb_cyc_o,
    input  logic [31:0]          m_wb_dat_i,
    input  logic                 m_wb_ack_i,
    input  logic                 m_wb_stall_i
);

    localparam int               IDX_W     = idx_width(NPORTS);
    localparam int               OUT_W     = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [OUT_W-1:0] OUT_MAX   = OUT_W'(MAX_OUTSTANDING);
    localparam logic [IDX_W-1:0] LAST_PORT = IDX_W'(NPORTS - 1);

    arb_state_t       state_q, state_d;
    logic [IDX_W-1:0] grant_q, grant_d;
    logic [IDX_W-1:0] prio_q, prio_d;
    logic [OUT_W-1:0] outstanding_q, outstanding_d;

    logic [IDX_W-1:0] w_pick;
    logic             w_pick_valid;
    logic             w_own_cyc;
    logic             w_full;
    logic             w_limit;
    logic             w_accept;

    logic [31:0] w_adr [NPORTS];
    logic [31:0] w_dat [NPORTS];
    logic [3:0]  w_sel [NPORTS];

    for (genvar k = 0; k < NPORTS; k++) begin : g_unpack
        assign w_adr[k] = s_wb_adr_i[32*k +: 32];
        assign w_dat[k] = s_wb_dat_i[32*k +: 32];
        assign w_sel[k] = s_wb_sel_i[4*k +: 4];
    end

    rr_priority_picker #(
        .NPORTS (NPORTS)
    ) u_picker (
        .req_i   (s_wb_cyc_i),
        .prio_i  (prio_q),
        .grant_o (w_pick),
        .valid_o (w_pick_valid)
    );

    assign w_own_cyc = s_wb_cyc_i[grant_q];
    assign w_full    = (outstanding_q == OUT_MAX);
    assign w_accept  = m_wb_stb_o & ~m_wb_stall_i;

`ifdef ECAP5_DPROC_ARB_BURST_LIMIT_EN
    localparam int BURST_W = $clog2(MAX_BURST + 1);

    logic [BURST_W-1:0] burst_q, burst_d;

    assign w_limit = (burst_q == BURST_W'(MAX_BURST));

    always_comb begin
        burst_d = burst_q;
        if (state_q != GRANT || !w_own_cyc) begin
            burst_d = '0;
        end else if (w_accept) begin
            burst_d = burst_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            burst_q <= '0;
        end else begin
            burst_q <= burst_d;
        end
    end
`else
    // MAX_BURST only has meaning when the burst limit is compiled in.
    logic [31:0] w_unused_max_burst;
    assign w_unused_max_burst = 32'(MAX_BURST);
    assign w_limit            = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            grant_q       <= '0;
            prio_q        <= '0;
            outstanding_q <= '0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            prio_q        <= prio_d;
            outstanding_q <= outstanding_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        prio_d        = prio_q;
        outstanding_d = outstanding_q;
        case (state_q)
            IDLE: begin
                if (w_pick_valid) begin
                    state_d = GRANT;
                    grant_d = w_pick;
                end
            end
            GRANT: begin
                // Dropping CYC abandons any late acks, so the tracker restarts.
                if (!w_own_cyc) begin
                    state_d       = IDLE;
                    prio_d        = (grant_q == LAST_PORT) ? '0 : grant_q + 1'b1;
                    outstanding_d = '0;
                end else if (w_accept && !m_wb_ack_i) begin
                    outstanding_d = outstanding_q + 1'b1;
                end else if (!w_accept && m_wb_ack_i && outstanding_q != '0) begin
                    outstanding_d = outstanding_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        m_wb_adr_o   = '0;
        m_wb_dat_o   = '0;
        m_wb_we_o    = 1'b0;
        m_wb_sel_o   = '0;
        m_wb_stb_o   = 1'b0;
        m_wb_cyc_o   = 1'b0;
        s_wb_stall_o = '1;
        s_wb_ack_o   = '0;
        s_wb_dat_o   = '0;
        if (state_q == GRANT) begin
            m_wb_adr_o            = w_adr[grant_q];
            m_wb_dat_o            = w_dat[grant_q];
            m_wb_we_o             = s_wb_we_i[grant_q];
            m_wb_sel_o            = w_sel[grant_q];
            m_wb_cyc_o            = w_own_cyc;
            m_wb_stb_o            = w_own_cyc & s_wb_stb_i[grant_q] & ~w_full & ~w_limit;
            s_wb_stall_o[grant_q] = m_wb_stall_i | w_full | w_limit;
            s_wb_ack_o[grant_q]   = m_wb_ack_i;
            for (int k = 0; k < NPORTS; k++) begin
                if (IDX_W'(k) == grant_q) begin
                    s_wb_dat_o[32*k +: 32] = m_wb_dat_i;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_wb_rr_arbiter.sv
// ============================================================================
//  Module   : tb_wb_rr_arbiter
//  Brief    : Self-checking bench for wb_rr_arbiter: directed scenarios plus
//             randomized traffic against a behavioural ownership model.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_wb_rr_arbiter;

    localparam int NP = 3;
    localparam int MO = 4;
    localparam int MB = 8;
`ifdef ECAP5_DPROC_ARB_BURST_LIMIT_EN
    localparam bit BURST_EN = 1'b1;
`else
    localparam bit BURST_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NP*32-1:0] s_adr = '0, s_dat_w = '0, s_dat_r;
    logic [NP-1:0]   s_we = '0, s_stb = '0, s_cyc = '0, s_ack, s_stall;
    logic [NP*4-1:0] s_sel = '0;
    logic [31:0]     m_adr, m_dat_w, m_dat_r = '0;
    logic            m_we, m_stb, m_cyc, m_ack = 1'b0, m_stall = 1'b0;
    logic [3:0]      m_sel;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wb_rr_arbiter #(
        .NPORTS          (NP),
        .MAX_OUTSTANDING (MO),
        .MAX_BURST       (MB)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .s_wb_adr_i   (s_adr),
        .s_wb_dat_i   (s_dat_w),
        .s_wb_dat_o   (s_dat_r),
        .s_wb_we_i    (s_we),
        .s_wb_sel_i   (s_sel),
        .s_wb_stb_i   (s_stb),
        .s_wb_cyc_i   (s_cyc),
        .s_wb_ack_o   (s_ack),
        .s_wb_stall_o (s_stall),
        .m_wb_adr_o   (m_adr),
        .m_wb_dat_o   (m_dat_w),
        .m_wb_we_o    (m_we),
        .m_wb_sel_o   (m_sel),
        .m_wb_stb_o   (m_stb),
        .m_wb_cyc_o   (m_cyc),
        .m_wb_dat_i   (m_dat_r),
        .m_wb_ack_i   (m_ack),
        .m_wb_stall_i (m_stall)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Behavioural model: owner index (-1 when the bus is free), rotation
    // pointer, count of unanswered accepted strobes, strobes this grant.
    int own = -1, ptr = 0, outst = 0, burst = 0;
    logic [70:0]      e_m;
    logic [NP-1:0]    e_stall, e_ack;
    logic [NP*32-1:0] e_dat;
    bit g_cyc, g_stb, blocked, acc;

    always @(negedge clk) begin
        if (rst) begin
            own = -1; ptr = 0; outst = 0; burst = 0;
        end
        e_m = '0; e_stall = '1; e_ack = '0; e_dat = '0;
        g_cyc = 1'b0; g_stb = 1'b0;
        if (own >= 0) begin
            g_cyc   = s_cyc[own];
            blocked = (outst == MO) || (BURST_EN && burst >= MB);
            g_stb   = g_cyc && s_stb[own] && !blocked;
            e_m     = {s_adr[own*32 +: 32], s_dat_w[own*32 +: 32], s_we[own],
                       s_sel[own*4 +: 4], g_stb, g_cyc};
            e_stall[own]          = m_stall || blocked;
            e_ack[own]            = m_ack;
            e_dat[own*32 +: 32]   = m_dat_r;
        end
        check("model_m_bus", {m_adr, m_dat_w, m_we, m_sel, m_stb, m_cyc}, e_m);
        check("model_stall", s_stall, e_stall);
        check("model_ack",   s_ack,   e_ack);
        check("model_s_dat", s_dat_r, e_dat);
        if (!rst) begin
            if (own < 0) begin
                for (int i = 0; i < NP; i++)
                    if (own < 0 && s_cyc[(ptr + i) % NP]) own = (ptr + i) % NP;
            end else if (!g_cyc) begin
                ptr = (own + 1) % NP; own = -1; outst = 0; burst = 0;
            end else begin
                acc   = g_stb && !m_stall;
                outst = outst + int'(acc) - int'(m_ack);
                if (outst < 0) outst = 0;
                burst = burst + int'(acc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        s_cyc = '0; s_stb = '0; s_we = '0;
        m_ack = 1'b0; m_stall = 1'b0; m_dat_r = '0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        idle_inputs();
        tick();
        tick();
        rst = 1'b0;
    endtask

    int order [4] = '{0, 1, 2, 0};
    logic [NP-1:0] onehot;
    logic [31:0]   exp_adr;

    initial begin
        s_adr = {32'h0000_3000, 32'h0000_2000, 32'h0000_1000};
        s_dat_w = {32'hC0C0_0002, 32'hC0C0_0001, 32'hC0C0_0000};
        s_sel = 12'hF0F;

        // Reset state and single read on port 1
        do_reset();
        #1;
        check("rst_stall", s_stall, 3'b111);
        check("rst_cyc", m_cyc, 1'b0);
        check("rst_ack", s_ack, 3'b000);
        s_cyc = 3'b010; s_stb = 3'b010;
        #1;
        check("p1_arb_latency", m_cyc, 1'b0);
        tick();
        #1;
        check("p1_grant_cyc", m_cyc, 1'b1);
        check("p1_grant_adr", m_adr, 32'h0000_2000);
        check("p1_stall_vec", s_stall, 3'b101);
        tick();
        s_stb = 3'b000;
        tick();
        m_ack = 1'b1; m_dat_r = 32'hDEAD_BEEF;
        #1;
        check("p1_ack_vec", s_ack, 3'b010);
        check("p1_read_dat", s_dat_r, {32'h0, 32'hDEAD_BEEF, 32'h0});
        check("p1_others_stall", {s_stall[2], s_stall[0]}, 2'b11);
        tick();
        m_ack = 1'b0; m_dat_r = '0; s_cyc = 3'b000;
        #1;
        check("p1_release_cyc", m_cyc, 1'b0);

        // All ports requesting: rotation 0,1,2,0 with a dead cycle between owners
        do_reset();
        s_cyc = 3'b111; s_stb = 3'b111;
        foreach (order[j]) begin
            tick();
            exp_adr = 32'h1000 * (order[j] + 1);
            #1;
            check("rr_grant_adr", m_adr, exp_adr);
            check("rr_grant_cyc", m_cyc, 1'b1);
            tick();
            s_stb[order[j]] = 1'b0; m_ack = 1'b1;
            onehot = '0; onehot[order[j]] = 1'b1;
            #1;
            check("rr_ack_owner", s_ack, onehot);
            tick();
            m_ack = 1'b0; s_cyc[order[j]] = 1'b0;
            #1;
            check("rr_release_cyc", m_cyc, 1'b0);
            tick();
            s_cyc[order[j]] = 1'b1; s_stb[order[j]] = 1'b1;
            #1;
            check("rr_idle_gap", m_cyc, 1'b0);
        end

        // Outstanding limit: four accepted, fifth held until one ack
        do_reset();
        s_cyc = 3'b001; s_stb = 3'b001;
        tick();
        for (int i = 0; i < 4; i++) begin
            #1;
            check("out_accept_stb", {m_stb, s_stall[0]}, 2'b10);
            tick();
        end
        #1;
        check("out_full_block", {m_stb, s_stall[0]}, 2'b01);
        tick();
        m_ack = 1'b1;
        #1;
        check("out_full_during_ack", m_stb, 1'b0);
        tick();
        m_ack = 1'b0;
        #1;
        check("out_fifth_accept", m_stb, 1'b1);
        tick();
        #1;
        check("out_full_again", m_stb, 1'b0);

        // Simultaneous accept and ack at two outstanding keeps the count
        do_reset();
        s_cyc = 3'b001; s_stb = 3'b001;
        tick(); tick(); tick();
        m_ack = 1'b1;
        #1;
        check("sim_acc_ack_stb", m_stb, 1'b1);
        tick();
        m_ack = 1'b0;
        #1;
        check("sim_count2_stb", m_stb, 1'b1);
        tick();
        #1;
        check("sim_count3_stb", m_stb, 1'b1);
        tick();
        #1;
        check("sim_count4_full", m_stb, 1'b0);

        // Asynchronous reset while port 2 owns the bus
        do_reset();
        s_cyc = 3'b100;
        tick();
        #1;
        check("ar_owner_cyc", m_cyc, 1'b1);
        check("ar_owner_adr", m_adr, 32'h0000_3000);
        #1;
        rst = 1'b1;
        #1;
        check("ar_cyc_dropped", m_cyc, 1'b0);
        check("ar_all_stall", s_stall, 3'b111);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        s_cyc = 3'b111;
        #1;
        check("ar_idle_after", m_cyc, 1'b0);
        tick();
        #1;
        check("ar_restart_port0", {m_cyc, m_adr}, {1'b1, 32'h0000_1000});

`ifdef ECAP5_DPROC_ARB_BURST_LIMIT_EN
        // Burst limit: port 1 streams, eight strobes pass, then held
        do_reset();
        s_cyc = 3'b110; s_stb = 3'b010; m_ack = 1'b1;
        tick();
        for (int i = 0; i < MB; i++) begin
            #1;
            check("bl_accept_stb", m_stb, 1'b1);
            tick();
        end
        #1;
        check("bl_limit_block", {m_stb, s_stall[1]}, 2'b01);
        tick();
        #1;
        check("bl_limit_hold", {m_stb, s_stall[1]}, 2'b01);
        s_cyc[1] = 1'b0; s_stb = '0; m_ack = 1'b0;
        tick();
        #1;
        check("bl_idle_gap", m_cyc, 1'b0);
        tick();
        #1;
        check("bl_next_port2", {m_cyc, m_adr}, {1'b1, 32'h0000_3000});
`endif

        // Randomized traffic checked by the model on every cycle
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            tick();
            for (int k = 0; k < NP; k++) begin
                if (!s_cyc[k]) begin
                    s_cyc[k] = ($urandom_range(3) == 0);
                    s_stb[k] = s_cyc[k] && ($urandom_range(1) == 1);
                end else if ($urandom_range(9) == 0) begin
                    s_cyc[k] = 1'b0;
                    s_stb[k] = 1'b0;
                end else begin
                    s_stb[k] = ($urandom_range(1) == 1);
                end
                s_we[k] = ($urandom_range(1) == 1);
                s_adr[k*32 +: 32]   = $urandom;
                s_dat_w[k*32 +: 32] = $urandom;
                s_sel[k*4 +: 4]     = 4'($urandom_range(15));
            end
            m_stall = ($urandom_range(3) == 0);
            m_ack   = ($urandom_range(2) == 0);
            m_dat_r = $urandom;
        end
        idle_inputs();
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
